cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have the following ports (clock and reset first):
- clk, input, 1: sole clock; all state updates on rising edge.
- rst_n, input, 1: reset; asynchronous, active-low.
- miss_detected, input, 1: I- or D-cache lookup missed this cycle.
- miss_address, input, 16: byte address of the missing access.
- memory_data, input, 16: word returned by main memory.
- memory_data_valid, input, 1: memory_data valid this cycle.
- fsm_busy, output, 1: fill in progress; pipeline stalls IF/MEM while high.
- mem_read_en, output, 1: issue a read request to main memory this cycle.
- memory_address, output, 16: byte address of the current read request.
- write_data_array, output, 1: write memory_data into the data array this cycle.
- word_index, output, 3: word slot in the block for write_data_array.
- write_tag_array, output, 1: write the tag for miss_address; one-cycle pulse.
REQ-002 SHALL have parameter MEM_LATENCY, default 4: cycles from request to matching memory_data_valid (informational; the FSM counts valid returns, not cycles).

Function
REQ-003 SHALL implement two states, IDLE and WAIT, held in a flop with asynchronous active-low reset.
REQ-004 Block geometry: 16 bytes = 8 words of 16 bits; block base = miss_address with bits [3:0] cleared.
REQ-005 IDLE with miss_detected=1: fsm_busy=1 combinationally in the same cycle; base latched; next state WAIT; issue counter and return counter cleared to 0.
REQ-006 IDLE with miss_detected=0: all outputs 0; state unchanged.
REQ-007 WAIT: fsm_busy=1 every cycle.
REQ-008 WAIT: mem_read_en=1 while issue counter < 8; memory_address = base + 2*issue counter; issue counter increments each cycle mem_read_en=1. Requests are therefore 8 back-to-back cycles starting in the first WAIT cycle.
REQ-009 Issue counter is 4 bits and saturates at 8; mem_read_en=0 and memory_address=0 once it reaches 8.
REQ-010 WAIT with memory_data_valid=1: write_data_array=1 and word_index = return counter[2:0]; return counter increments.
REQ-011 Memory returns words in request order; the return counter, not memory_address, selects the slot.
REQ-012 Return of the 8th word (return counter = 7 with memory_data_valid=1): write_tag_array=1 in the same cycle; next state IDLE.
REQ-013 fsm_busy SHALL drop in the cycle after the 8th write.
REQ-014 Issue and return overlap freely; valid returns arriving while requests are still being issued are accepted.
REQ-015 miss_detected in WAIT is ignored. The latched base does not change until the fill completes.
REQ-016 memory_data_valid in IDLE is ignored: no write_data_array, no counter change.
REQ-017 miss_detected in the first IDLE cycle after completion starts a new fill (zero-bubble re-entry).
REQ-018 Address arithmetic is 16-bit; base is 16-byte aligned, so base+14 cannot wrap (base 0xFFF0 gives a last address of 0xFFFE).
REQ-019 write_data_array, write_tag_array and mem_read_en SHALL be 0 whenever fsm_busy=0.

Reset
REQ-020 rst_n=0: state=IDLE; counters and base=0; all outputs 0 immediately (asynchronous), regardless of state.
REQ-021 Reset mid-fill aborts the fill: no tag write; the partial block is left to the cache's valid-bit logic. After release, the FSM waits in IDLE for a new miss.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Miss at 0x1236, memory valid 4 cycles after each request → requests 0x1230..0x123E on 8 consecutive cycles; writes word_index 0..7; write_tag_array with word 7; fsm_busy high for 1+11 cycles, then 0.
- Miss at 0xFFF8 → addresses 0xFFF0..0xFFFE; no wrap; 8 writes; one tag pulse.
- Memory valid gapped (returns on alternate cycles) → word_index still 0..7 in order; FSM stays WAIT until the 8th return.
- miss_detected held high throughout, with miss_address changed mid-fill to 0x4000 → original addresses only; a second fill starts the cycle after completion, with base 0x4000.
- rst_n low after 3 returns → outputs 0 asynchronously; no tag write; after release with no miss, fsm_busy stays 0 and stray memory_data_valid causes no writes.
- Stray memory_data_valid in IDLE → write_data_array=0 and counters unchanged; the next miss writes word_index starting at 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block-fill controller for a cache miss.
// On a miss it fetches one 16-byte block as 8 sequential 16-bit word reads
// from main memory. It writes each returned word into the data array and
// writes the tag when the 8th word arrives.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   miss_detected       cache lookup missed this cycle
//   miss_address[15:0]  byte address of the missing access
//   memory_data[15:0]   returned word (routed to the data array outside this block)
//   memory_data_valid   returned word valid this cycle
//   fsm_busy            fill in progress (stalls IF/MEM)
//   mem_read_en         read request to memory this cycle
//   memory_address      byte address of the current read request
//   write_data_array    write returned word into the data array
//   word_index[2:0]     word slot within the block for that write
//   write_tag_array     one-cycle tag write pulse on the last word
module cache_fill_fsm #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_read_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  word_index,
  output logic        write_tag_array
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_base,  w_base_nxt;
  logic [3:0]  r_issue, w_issue_nxt;   // requests issued, saturates at 8
  logic [2:0]  r_ret,   w_ret_nxt;     // words returned so far

  // The FSM counts returns rather than cycles, and the data path lives
  // outside this block, so neither input has a consumer here.
  logic w_unused;
  assign w_unused = ^{memory_data, MEM_LATENCY[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_issue <= '0;
      r_ret   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_issue <= w_issue_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_issue_nxt      = r_issue;
    w_ret_nxt        = r_ret;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (miss_detected) begin
          fsm_busy    = 1'b1;
          w_state_nxt = S_WAIT;
          w_base_nxt  = {miss_address[15:4], 4'h0};
          w_issue_nxt = '0;
          w_ret_nxt   = '0;
        end
      end
      S_WAIT: begin
        fsm_busy = 1'b1;
        if (r_issue < 4'd8) begin
          mem_read_en    = 1'b1;
          // Base is 16-byte aligned, so base + 14 never carries out.
          memory_address = r_base + {11'b0, r_issue, 1'b0};
          w_issue_nxt    = r_issue + 4'd1;
        end
        // Memory returns in request order, so the return count picks the slot.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = r_ret;
          w_ret_nxt        = r_ret + 3'd1;
          if (r_ret == 3'd7) begin
            write_tag_array = 1'b1;
            w_state_nxt     = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Outputs must go quiet the moment reset asserts, even while a miss
    // input is still high.
    if (!rst_n) begin
      fsm_busy         = 1'b0;
      mem_read_en      = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      word_index       = '0;
      write_tag_array  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic        write_tag_array;

  cache_fill_fsm #(.MEM_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en),
    .memory_address(memory_address), .write_data_array(write_data_array),
    .word_index(word_index), .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected request addresses / write slots, and memory return schedule
  logic [15:0] exp_addr_q[$];
  logic [2:0]  exp_idx_q[$];
  int          due_q[$];

  // One fill: miss cycle, then WAIT cycles until the tag pulse. A request in
  // WAIT cycle c returns in cycle max(c+3, previous return + gap), i.e. on the
  // 4th cycle counting the request cycle when ungapped.
  task automatic run_fill(input logic [15:0] maddr, input int gap, input bit hold,
                          input logic [15:0] mid_addr, input int abort_after,
                          output int busy_cyc, output int tags);
    logic [15:0] base;
    logic [15:0] ea;
    logic [2:0]  ei;
    int writes, last_due, d;
    bit done;
    base = {maddr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(base + 16'(2 * i));
      exp_idx_q.push_back(3'(i));
    end
    due_q.delete();
    last_due = -100; writes = 0; tags = 0; done = 0;
    @(negedge clk);
    miss_detected = 1'b1; miss_address = maddr; memory_data_valid = 1'b0;
    #1;
    checks++;
    if (fsm_busy !== 1'b1 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0)
      begin errors++; $display("FAIL miss_cycle busy=%b rd=%b wr=%b tag=%b want 1 0 0 0", fsm_busy, mem_read_en, write_data_array, write_tag_array); end
    busy_cyc = 1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      miss_detected = hold;
      miss_address = (hold && cyc >= 2) ? mid_addr : maddr;
      memory_data = 16'($urandom);
      memory_data_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        memory_data_valid = 1'b1;
        void'(due_q.pop_front());
      end
      #1;
      if (fsm_busy === 1'b1) busy_cyc++;
      checks++;
      if (fsm_busy !== 1'b1) begin errors++; $display("FAIL wait_busy cyc=%0d got %b want 1", cyc, fsm_busy); end
      if (mem_read_en === 1'b1) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++; $display("FAIL extra_request cyc=%0d addr=%h", cyc, memory_address);
        end else begin
          ea = exp_addr_q.pop_front();
          if (memory_address !== ea) begin errors++; $display("FAIL req_addr cyc=%0d got %h want %h", cyc, memory_address, ea); end
        end
        d = (cyc + 3 > last_due + gap) ? cyc + 3 : last_due + gap;
        due_q.push_back(d);
        last_due = d;
      end else begin
        checks++;
        if (memory_address !== 16'h0) begin errors++; $display("FAIL idle_addr cyc=%0d got %h want 0000", cyc, memory_address); end
      end
      checks++;
      if (write_data_array !== memory_data_valid) begin errors++; $display("FAIL write_en cyc=%0d got %b want %b", cyc, write_data_array, memory_data_valid); end
      if (write_data_array === 1'b1) begin
        writes++;
        checks++;
        if (exp_idx_q.size() == 0) begin
          errors++; $display("FAIL extra_write cyc=%0d idx=%0d", cyc, word_index);
        end else begin
          ei = exp_idx_q.pop_front();
          if (word_index !== ei) begin errors++; $display("FAIL word_index cyc=%0d got %0d want %0d", cyc, word_index, ei); end
        end
      end
      if (write_tag_array === 1'b1) begin
        tags++;
        checks++;
        if (writes != 8) begin errors++; $display("FAIL tag_early writes=%0d want 8", writes); end
        done = 1;
      end
      if (abort_after > 0 && writes == abort_after) return;
    end
    if (!done) begin checks++; errors++; $display("FAIL fill_timeout maddr=%h no tag pulse", maddr); end
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    miss_detected = 1'b0; memory_data_valid = 1'b0;
    #1;
    checks++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0)
      begin errors++; $display("FAIL %s_idle busy=%b rd=%b wr=%b tag=%b want 0 0 0 0", nm, fsm_busy, mem_read_en, write_data_array, write_tag_array); end
  endtask

  task automatic check_done(input string nm, input int busy_cyc, input int tags, input int exp_busy);
    checks++;
    if (busy_cyc != exp_busy) begin errors++; $display("FAIL %s_busy_len got %0d want %0d", nm, busy_cyc, exp_busy); end
    checks++;
    if (tags != 1) begin errors++; $display("FAIL %s_tags got %0d want 1", nm, tags); end
    checks++;
    if (exp_addr_q.size() != 0 || exp_idx_q.size() != 0)
      begin errors++; $display("FAIL %s_left reqs=%0d writes=%0d want 0 0", nm, exp_addr_q.size(), exp_idx_q.size()); end
    exp_addr_q.delete(); exp_idx_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_detected = 1'b1; miss_address = 16'h1236;
    memory_data = 16'h0; memory_data_valid = 1'b1;
    #12;
    checks++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0 || memory_address !== 16'h0 || word_index !== 3'd0)
      begin errors++; $display("FAIL reset_outputs busy=%b rd=%b wr=%b tag=%b addr=%h idx=%0d want all 0", fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address, word_index); end
    @(negedge clk);
    rst_n = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0;
    check_idle("post_reset");
  endtask

  task automatic test_basic();
    int b, t;
    run_fill(16'h1236, 1, 1'b0, 16'h0, 0, b, t);
    check_done("basic", b, t, 12);
    check_idle("basic");
  endtask

  task automatic test_top_of_memory();
    int b, t;
    run_fill(16'hFFF8, 1, 1'b0, 16'h0, 0, b, t);
    check_done("top", b, t, 12);
    check_idle("top");
  endtask

  task automatic test_gapped();
    int b, t;
    run_fill(16'h0A52, 2, 1'b0, 16'h0, 0, b, t);
    check_done("gapped", b, t, 19);
    check_idle("gapped");
  endtask

  task automatic test_back_to_back();
    int b, t;
    run_fill(16'h2A5C, 1, 1'b1, 16'h4000, 0, b, t);
    check_done("b2b_first", b, t, 12);
    run_fill(16'h4000, 1, 1'b0, 16'h0, 0, b, t);
    check_done("b2b_second", b, t, 12);
    check_idle("b2b");
  endtask

  task automatic test_reset_mid_fill();
    int b, t;
    run_fill(16'h3000, 1, 1'b0, 16'h0, 3, b, t);
    #2;
    rst_n = 1'b0; miss_detected = 1'b1; memory_data_valid = 1'b1;
    #1;
    checks++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0 || memory_address !== 16'h0)
      begin errors++; $display("FAIL abort_async busy=%b rd=%b wr=%b tag=%b addr=%h want all 0", fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address); end
    checks++;
    if (t != 0) begin errors++; $display("FAIL abort_tag got %0d want 0", t); end
    exp_addr_q.delete(); exp_idx_q.delete(); due_q.delete();
    @(negedge clk);
    rst_n = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      miss_detected = 1'b0; memory_data_valid = (i % 2 == 0);
      #1;
      checks++;
      if (fsm_busy !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0 || mem_read_en !== 1'b0)
        begin errors++; $display("FAIL abort_after_release i=%0d busy=%b wr=%b tag=%b rd=%b want 0 0 0 0", i, fsm_busy, write_data_array, write_tag_array, mem_read_en); end
    end
  endtask

  task automatic test_stray_valid_idle();
    int b, t;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      miss_detected = 1'b0; memory_data_valid = 1'b1;
      #1;
      checks++;
      if (write_data_array !== 1'b0 || fsm_busy !== 1'b0)
        begin errors++; $display("FAIL stray_valid i=%0d wr=%b busy=%b want 0 0", i, write_data_array, fsm_busy); end
    end
    run_fill(16'h8888, 1, 1'b0, 16'h0, 0, b, t);
    check_done("stray", b, t, 12);
    check_idle("stray");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_of_memory();
    test_gapped();
    test_back_to_back();
    test_reset_mid_fill();
    test_stray_valid_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
